// File: rtl/lookahead_sub_32bit_pipe_pkg.sv
// Shared constants, the pipeline stage record and the lookahead carry helper
// for the pipelined 32-bit lookahead subtractor.
package lookahead_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int STAGES = WIDTH / SLICE;

  // One pipeline rank: consumed operand bits are cleared and finished
  // difference bits are filled in as the pair moves forward.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a_pend;
    logic [WIDTH-1:0] b_pend;
    logic [WIDTH-1:0] diff_done;
  } stage_t;

  // Carry-in is 1 so that a + ~b + 1 starts correctly in the first slice.
  localparam stage_t STAGE_RESET = '{valid: 1'b0, carry: 1'b1, default: '0};

  // Carry into bit i+1, flattened from generate/propagate terms.
  function automatic logic lookahead_carry(input logic [SLICE-1:0] g,
                                           input logic [SLICE-1:0] p,
                                           input logic             cin,
                                           input int               i);
    logic c;
    logic prod;
    c    = g[i];
    prod = p[i];
    for (int j = i - 1; j >= 0; j--) begin
      c    = c | (prod & g[j]);
      prod = prod & p[j];
    end
    return c | (prod & cin);
  endfunction

endpackage

// File: rtl/lookahead_sub_32bit_pipe_if.sv
// Operand/result handshake bundle for lookahead_sub_32bit_pipe.
// Both sides use valid/ready: a transfer happens on a clock edge where valid and ready are both 1.
interface lookahead_sub_32bit_pipe_if;
  import lookahead_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );

endinterface

// File: rtl/lookahead_sub_32bit_pipe_slice.sv
// Combinational 8-bit carry-lookahead adder slice; fed with a, ~b and the
// incoming carry it produces one byte of a - b and the carry to the next slice.
module lookahead_sub_slice
  import lookahead_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b_n,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;

  assign g    = a & b_n;
  assign p    = a ^ b_n;
  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_carry
    assign c[i+1] = lookahead_carry(g, p, cin, i);
  end

  assign sum  = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

// File: rtl/lookahead_sub_32bit_pipe.sv
// Pipelined 32-bit unsigned subtractor: input register plus one lookahead slice per stage.
// Define LOOKAHEAD_SUB_SAT_EN to clamp diff to zero whenever borrow is set.
module lookahead_sub_32bit_pipe
  import lookahead_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  lookahead_sub_32bit_pipe_if.slave bus
);

  stage_t in_q;
  stage_t last;
  logic   stall;
  logic   borrow;

  // The whole pipe freezes together, so bubbles keep their slots.
  assign stall        = last.valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= STAGE_RESET;
    end else if (!stall) begin
      in_q <= '{valid: bus.in_valid, carry: 1'b1, a_pend: bus.a,
                b_pend: bus.b, diff_done: '0};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    stage_t           q;
    logic [SLICE-1:0] sum;
    logic             cout;

    if (k == 0) begin : g_first
      assign src = in_q;
    end else begin : g_rest
      assign src = g_stage[k-1].q;
    end

    lookahead_sub_slice u_slice (
      .a    (src.a_pend[k*SLICE +: SLICE]),
      .b_n  (~src.b_pend[k*SLICE +: SLICE]),
      .cin  (src.carry),
      .sum  (sum),
      .cout (cout)
    );

    always_comb begin
      nxt                            = src;
      nxt.carry                      = cout;
      nxt.a_pend[k*SLICE +: SLICE]    = '0;
      nxt.b_pend[k*SLICE +: SLICE]    = '0;
      nxt.diff_done[k*SLICE +: SLICE] = sum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= STAGE_RESET;
      end else if (!stall) begin
        q <= nxt;
      end
    end
  end

  assign last          = g_stage[STAGES-1].q;
  assign borrow        = ~last.carry;
  assign bus.out_valid = last.valid;
  assign bus.borrow    = borrow;

`ifdef LOOKAHEAD_SUB_SAT_EN
  assign bus.diff = borrow ? '0 : last.diff_done;
`else
  assign bus.diff = last.diff_done;
`endif

endmodule
